bird_motion_ctrl: RTL

Parametrised frame-driven controller for the player bird. It replaces the fixed raise/fall FSM with signed velocity, gravity, flap impulse, ceiling/floor clamping and a request/done handshake to the VGA draw engine. It sits between the keyboard/key input, the pipe collision checker (`touched`) and the renderer, and exports the bird's vertical position for both.

---
 rtl/bird_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bird_motion_ctrl.sv
// rtl/bird_motion_ctrl.sv - frame-driven bird physics controller with renderer handshake
//
// Purpose:
//   Moves the player bird once per video frame using a signed velocity,
//   gravity, a flap impulse and ceiling/floor clamping. Requests a redraw
//   after every update and waits for the renderer before accepting the
//   next frame. Collisions and the floor kill the bird; a key press respawns it.
//   Optional macro BIRD_LIVES_EN enables a multi-life game (LIVES per game);
//   without it every death ends the game and lives reads as 1.
//
// Ports:
//   clk, resetn          system clock, synchronous active-low reset
//   frame_tick           one-cycle pulse per video frame
//   press_key            flap key (level, edge-detected internally)
//   touched              pipe collision (level, sampled in UPDATE)
//   draw_done            renderer finished drawing the bird (used in DRAW only)
//   draw_req             draw request, high for the whole DRAW state
//   bird_y               current row
//   bird_vel             signed velocity, positive is downward
//   state                FSM code: READY=0 WAIT=1 UPDATE=2 DRAW=3 DEAD=4
//   game_over            no lives remain
//   lives                remaining lives
//   overrun              one-cycle pulse for a frame_tick dropped outside READY/WAIT

module bird_motion_ctrl #(
  parameter int Y_W      = 8,
  parameter int V_W      = 5,
  parameter int Y_START  = 60,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 110,
  parameter int FLAP_VEL = 6,
  parameter int GRAVITY  = 1,
  parameter int VEL_MAX  = 4,
  parameter int LIVES    = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_tick,
  input  logic                  press_key,
  input  logic                  touched,
  input  logic                  draw_done,
  output logic                  draw_req,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] bird_vel,
  output logic [2:0]            state,
  output logic                  game_over,
  output logic [1:0]            lives,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_READY  = 3'd0,
    S_WAIT   = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_DEAD   = 3'd4
  } state_t;

  // Two guard bits so y + v can go below zero or above the row range
  // without wrapping before the clamp decisions are taken.
  localparam int YW2 = Y_W + 2;
  localparam int VW2 = V_W + 2;

  localparam logic signed [VW2-1:0] GRAV_S    = VW2'(GRAVITY);
  localparam logic signed [VW2-1:0] VMAX_S    = VW2'(VEL_MAX);
  localparam logic signed [VW2-1:0] FLAP_S    = VW2'(-FLAP_VEL);
  localparam logic signed [YW2-1:0] YMIN_S    = YW2'(Y_MIN);
  localparam logic signed [YW2-1:0] YMAX_S    = YW2'(Y_MAX);
  localparam logic [Y_W-1:0]        Y_START_V = Y_W'(Y_START);
  localparam logic [Y_W-1:0]        Y_MIN_V   = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]        Y_MAX_V   = Y_W'(Y_MAX);

  // Ceiling and floor handling assumes a non-empty play field.
  if (Y_MIN >= Y_MAX || LIVES < 1 || LIVES > 3) begin : g_bad_params
    $error("bird_motion_ctrl: illegal parameter set");
  end

  state_t                  state_q, state_d;
  state_t                  ret_q, ret_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic signed [V_W-1:0]   vel_q, vel_d;
  logic                    key_q;
  logic                    flap_pend_q, flap_pend_d;
  logic                    go_q, go_d;
  logic                    overrun_q, overrun_d;

  logic                    key_edge;
  logic                    respawn;
  logic                    lives_zero;
  logic signed [VW2-1:0]   v_inc;
  logic signed [VW2-1:0]   v_next;
  logic signed [YW2-1:0]   y_sum;
  logic                    hit_ceil;
  logic                    hit_floor;
  logic                    death;

  assign key_edge = press_key & ~key_q;
  assign respawn  = (state_q == S_DEAD) & key_edge;

  // Physics for the UPDATE cycle; only consumed while state_q is UPDATE.
  always_comb begin
    v_inc     = VW2'(vel_q) + GRAV_S;
    v_next    = flap_pend_q ? FLAP_S : ((v_inc > VMAX_S) ? VMAX_S : v_inc);
    y_sum     = $signed({2'b00, y_q}) + YW2'(v_next);
    hit_ceil  = (y_sum <= YMIN_S);
    hit_floor = (y_sum >= YMAX_S);
    death     = hit_floor | touched;
  end

`ifdef BIRD_LIVES_EN
  localparam logic [1:0] LIVES_V = 2'(LIVES);

  logic [1:0] lives_q, lives_d;

  always_comb begin
    lives_d = lives_q;
    if (state_q == S_UPDATE && death && lives_q != 2'd0) begin
      lives_d = lives_q - 2'd1;
    end else if (respawn && go_q) begin
      lives_d = LIVES_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lives_q <= LIVES_V;
    end else begin
      lives_q <= lives_d;
    end
  end

  // lives_q is already decremented by the time DRAW hands over to DEAD.
  assign lives_zero = (lives_q == 2'd0);
  assign lives      = lives_q;
`else
  // Single-life game: every death is final until the next press.
  assign lives_zero = 1'b1;
  assign lives      = 2'd1;
`endif

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    y_d         = y_q;
    vel_d       = vel_q;
    go_d        = go_q;
    flap_pend_d = flap_pend_q | key_edge;
    overrun_d   = frame_tick & ((state_q == S_UPDATE) | (state_q == S_DRAW) |
                                (state_q == S_DEAD));

    case (state_q)
      S_READY: begin
        y_d   = Y_START_V;
        vel_d = '0;
        if (frame_tick) begin
          // A pending flap starts the game straight away; otherwise just
          // redraw the idle bird and come back here.
          if (flap_pend_q) begin
            state_d = S_UPDATE;
          end else begin
            state_d = S_DRAW;
            ret_d   = S_READY;
          end
        end
      end

      S_WAIT: begin
        if (frame_tick) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        // The pending flap is consumed here; an edge landing in this very
        // cycle survives for the next frame.
        flap_pend_d = key_edge;
        vel_d       = v_next[V_W-1:0];
        if (hit_ceil) begin
          y_d   = Y_MIN_V;
          vel_d = '0;
        end else if (hit_floor) begin
          y_d = Y_MAX_V;
        end else begin
          y_d = y_sum[Y_W-1:0];
        end
        state_d = S_DRAW;
        ret_d   = death ? S_DEAD : S_WAIT;
      end

      S_DRAW: begin
        if (draw_done) begin
          state_d = ret_q;
          if (ret_q == S_DEAD) begin
            vel_d = '0;
            go_d  = lives_zero;
          end
        end
      end

      S_DEAD: begin
        vel_d = '0;
        if (key_edge) begin
          state_d = S_READY;
          y_d     = Y_START_V;
          go_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_READY;
        ret_d   = S_READY;
        y_d     = Y_START_V;
        vel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_READY;
      ret_q       <= S_READY;
      y_q         <= Y_START_V;
      vel_q       <= '0;
      key_q       <= 1'b0;
      flap_pend_q <= 1'b0;
      go_q        <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      key_q       <= press_key;
      flap_pend_q <= flap_pend_d;
      go_q        <= go_d;
      overrun_q   <= overrun_d;
    end
  end

  assign draw_req  = (state_q == S_DRAW);
  assign bird_y    = y_q;
  assign bird_vel  = vel_q;
  assign state     = state_q;
  assign game_over = go_q;
  assign overrun   = overrun_q;

endmodule
